contador_arb: RTL and testbench

//  Round-robin arbiter/scheduler for a shared bidirectional saturating counter.

---
 rtl/contador_arb_if.sv | 30 +++
 rtl/contador_arb.sv | 144 ++++++++++++++
 tb/tb_contador_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/contador_arb_if.sv
// Request/grant bundle between the counter clients and the contador_arb scheduler.
// The master side drives requests and the enable; the slave side is the arbiter.
interface contador_arb_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic             enable;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  dir;
    logic [NREQ-1:0]  lock;
    logic [NREQ-1:0]  gnt;
    logic             locked;
    logic [OW-1:0]    owner;
    logic             stall;
    logic [WIDTH-1:0] cuenta;
    logic             empty;
    logic             full;

    modport master (
        output enable, req, dir, lock,
        input  gnt, locked, owner, stall, cuenta, empty, full
    );

    modport slave (
        input  enable, req, dir, lock,
        output gnt, locked, owner, stall, cuenta, empty, full
    );
endinterface

// File: rtl/contador_arb.sv
// Round-robin scheduler for one shared up/down saturating counter.
// One step is granted per clock; steps that would wrap the count are held back.
// A granted requester holding lock keeps exclusive ownership for burst steps.

// Per-requester eligibility: a request is blocked only when its step would
// push the count past full (up) or below empty (down).
module contador_arb_lane (
    input  logic req,
    input  logic dir,
    input  logic full,
    input  logic empty,
    output logic elig,
    output logic blk
);
    assign elig = req & ~(dir & full) & ~(~dir & empty);
    assign blk  = req & ~elig;
endmodule

module contador_arb #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic           clk,
    input  logic           rst,
    contador_arb_if.slave  bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {FREE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             stall_q, stall_d;

    logic             full, empty;
    logic [NREQ-1:0]  elig, blk;
    logic             rr_found;
    logic [OW-1:0]    rr_win;
    logic [OW-1:0]    rr_nxt;
    logic [OW-1:0]    sel;
    logic [WIDTH-1:0] stepped;

    assign full  = &cuenta_q;
    assign empty = ~|cuenta_q;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_lane
            contador_arb_lane u_lane (
                .req   (bus.req[g]),
                .dir   (bus.dir[g]),
                .full  (full),
                .empty (empty),
                .elig  (elig[g]),
                .blk   (blk[g])
            );
        end
    endgenerate

    // Round-robin search: first eligible requester starting at ptr, wrapping mod NREQ.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_win   = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!rr_found && elig[idx]) begin
                rr_found = 1'b1;
                rr_win   = OW'(idx);
            end
        end
    end

    assign rr_nxt = (rr_win == OW'(NREQ - 1)) ? '0 : rr_win + OW'(1);

    // The stepped value only matters for whichever requester actually wins.
    assign sel     = (state_q == LOCKED && bus.lock[owner_q]) ? owner_q : rr_win;
    assign stepped = bus.dir[sel] ? cuenta_q + WIDTH'(1) : cuenta_q - WIDTH'(1);

    // Next-state and grant decision; lock release is checked before the owner
    // path so a dropped lock rearbitrates on the same edge.
    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        cuenta_d = cuenta_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        stall_d  = 1'b0;
        if (bus.enable) begin
            if (state_q == LOCKED && bus.lock[owner_q]) begin
                // Only the owner is considered; others neither win nor stall.
                stall_d = blk[owner_q];
                if (elig[owner_q]) begin
                    gnt_d[owner_q] = 1'b1;
                    cuenta_d       = stepped;
                end
            end else begin
                state_d = FREE;
                stall_d = |blk;
                if (rr_found) begin
                    gnt_d[rr_win] = 1'b1;
                    cuenta_d      = stepped;
                    ptr_d         = rr_nxt;
                    if (bus.lock[rr_win]) begin
                        state_d = LOCKED;
                        owner_d = rr_win;
                    end
                end
            end
        end
    end

    // State register; reset wins over enable and every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cuenta_q <= '0;
            gnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cuenta_q <= cuenta_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.locked = (state_q == LOCKED);
    assign bus.owner  = owner_q;
    assign bus.stall  = stall_q;
    assign bus.cuenta = cuenta_q;
    assign bus.empty  = empty;
    assign bus.full   = full;
endmodule

// File: tb/tb_contador_arb.sv
// Directed bench for contador_arb: fill, saturation, drain, lock bursts,
// freeze and reset-during-lock, each against hand-computed values.
module tb_contador_arb;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    contador_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    contador_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just past it; inputs change and outputs are
    // sampled here, well away from the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l);
        bus.req  = r;
        bus.dir  = d;
        bus.lock = l;
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        bus.enable = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        rst = 1'b0;
        // reset state
        chk("rst_gnt",    32'(bus.gnt),    0);
        chk("rst_cuenta", 32'(bus.cuenta), 0);
        chk("rst_stall",  32'(bus.stall),  0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_owner",  32'(bus.owner),  0);
        chk("rst_empty",  32'(bus.empty),  1);
        chk("rst_full",   32'(bus.full),   0);

        // 1: all up, rotating grants, count 0 -> 8
        drive(4'b1111, 4'b1111, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("t1_gnt%0d", k), 32'(bus.gnt), 32'(1 << (k % 4)));
            chk($sformatf("t1_cnt%0d", k), 32'(bus.cuenta), 32'(k + 1));
        end

        // 2: fill to 15 (winners 0,1,2,3,0,1,2 -> ptr=3), then saturate
        for (int k = 0; k < 7; k++) step();
        chk("t2_fill",  32'(bus.cuenta), 15);
        chk("t2_fullf", 32'(bus.full),   1);
        step();
        chk("t2_sat_gnt",   32'(bus.gnt),    0);
        chk("t2_sat_stall", 32'(bus.stall),  1);
        chk("t2_sat_cnt",   32'(bus.cuenta), 15);
        drive(4'b0001, 4'b0001, 4'b0000);
        step();
        chk("t2_up_gnt",   32'(bus.gnt),    0);
        chk("t2_up_stall", 32'(bus.stall),  1);
        chk("t2_up_cnt",   32'(bus.cuenta), 15);
        drive(4'b0011, 4'b0001, 4'b0000);
        step();
        chk("t2_dn_gnt",   32'(bus.gnt),    32'b0010);
        chk("t2_dn_cnt",   32'(bus.cuenta), 14);
        chk("t2_dn_stall", 32'(bus.stall),  1);

        // 3: drain 14 -> 0 from ptr=2, then hold at empty
        drive(4'b1111, 4'b0000, 4'b0000);
        base = 2;
        for (int k = 0; k < 14; k++) begin
            step();
            chk($sformatf("t3_gnt%0d", k), 32'(bus.gnt), 32'(1 << ((base + k) % 4)));
            chk($sformatf("t3_cnt%0d", k), 32'(bus.cuenta), 32'(13 - k));
        end
        step();
        chk("t3_emp_gnt",   32'(bus.gnt),    0);
        chk("t3_emp_stall", 32'(bus.stall),  1);
        chk("t3_emp_cnt",   32'(bus.cuenta), 0);
        chk("t3_emp_flag",  32'(bus.empty),  1);

        // 4: lock burst by requester 2 (ptr=0 on entry)
        drive(4'b0100, 4'b0100, 4'b0100);
        step();
        chk("t4_gnt",    32'(bus.gnt),    32'b0100);
        chk("t4_cnt",    32'(bus.cuenta), 1);
        chk("t4_locked", 32'(bus.locked), 1);
        chk("t4_owner",  32'(bus.owner),  2);
        drive(4'b0101, 4'b0101, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_b_gnt%0d", k), 32'(bus.gnt), 32'b0100);
            chk($sformatf("t4_b_cnt%0d", k), 32'(bus.cuenta), 32'(2 + k));
            chk($sformatf("t4_b_lck%0d", k), 32'(bus.locked), 1);
        end
        chk("t4_b_stall", 32'(bus.stall), 0);
        drive(4'b1101, 4'b1101, 4'b0000);
        step();
        chk("t4_rel_gnt",    32'(bus.gnt),    32'b1000);
        chk("t4_rel_cnt",    32'(bus.cuenta), 5);
        chk("t4_rel_locked", 32'(bus.locked), 0);

        // 5: freeze with pending requests (ptr=0), then resume
        drive(4'b1111, 4'b1111, 4'b0000);
        bus.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5_gnt%0d", k), 32'(bus.gnt), 0);
            chk($sformatf("t5_cnt%0d", k), 32'(bus.cuenta), 5);
            chk($sformatf("t5_stl%0d", k), 32'(bus.stall), 0);
        end
        bus.enable = 1'b1;
        step();
        chk("t5_res_gnt0", 32'(bus.gnt),    32'b0001);
        chk("t5_res_cnt0", 32'(bus.cuenta), 6);
        step();
        chk("t5_res_gnt1", 32'(bus.gnt),    32'b0010);
        chk("t5_res_cnt1", 32'(bus.cuenta), 7);

        // 6: lock by 2 up to count 9, then reset mid-lock (ptr=3 before reset)
        drive(4'b0100, 4'b0100, 4'b0100);
        step();
        step();
        chk("t6_cnt",    32'(bus.cuenta), 9);
        chk("t6_locked", 32'(bus.locked), 1);
        rst = 1'b1;
        step();
        chk("t6_rst_cnt",    32'(bus.cuenta), 0);
        chk("t6_rst_locked", 32'(bus.locked), 0);
        chk("t6_rst_gnt",    32'(bus.gnt),    0);
        chk("t6_rst_owner",  32'(bus.owner),  0);
        rst = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0000);
        step();
        chk("t6_ptr0_gnt", 32'(bus.gnt),    32'b0001);
        chk("t6_ptr0_cnt", 32'(bus.cuenta), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
